// File: rtl/add_frac_stage.sv
// FP16 add pipeline, fraction add/subtract stage.
// Signed-magnitude add of aligned fractions into a 2-entry result buffer.
module add_frac_stage (
    input  logic        clk,
    input  logic        nRST,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        sign_shifted,
    input  logic [12:0] frac_shifted,
    input  logic        sign_not_shifted,
    input  logic [12:0] frac_not_shifted,
    input  logic [4:0]  exp_max,
    input  logic        rounding_loss,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_sign,
    output logic [13:0] out_frac,
    output logic [4:0]  out_exp,
    output logic        out_sticky,
    output logic        out_zero,
    output logic        out_special
);

    typedef struct packed {
        logic        sign;
        logic [13:0] frac;
        logic [4:0]  exp;
        logic        sticky;
        logic        zero;
        logic        special;
    } res_t;

    localparam logic [4:0] EXP_SPECIAL = 5'h1F;

    res_t        res_d;
    res_t        mem_q [2];
    res_t        head;
    logic [1:0]  count_q, count_d;
    logic        wr_ptr_q, wr_ptr_d;
    logic        rd_ptr_q, rd_ptr_d;
    logic [13:0] n_ext;
    logic [13:0] s_ext;
    logic        same_sign;
    logic        n_ge_s;
    logic        n_eq_s;
    logic        push;
    logic        pop;

    // Signed-magnitude add/subtract of the incoming operand set.
    always_comb begin
        n_ext     = {1'b0, frac_not_shifted};
        s_ext     = {1'b0, frac_shifted};
        same_sign = (sign_shifted == sign_not_shifted);
        n_ge_s    = (n_ext >= s_ext);
        n_eq_s    = (n_ext == s_ext);
        res_d     = '0;
        if (same_sign) begin
            res_d.frac = n_ext + s_ext;
            res_d.sign = sign_not_shifted;
        end else if (n_ge_s) begin
            res_d.frac = n_ext - s_ext;
            res_d.sign = n_eq_s ? 1'b0 : sign_not_shifted;
        end else begin
            res_d.frac = s_ext - n_ext;
            res_d.sign = sign_shifted;
        end
        res_d.exp     = exp_max;
        res_d.sticky  = rounding_loss;
        res_d.zero    = (res_d.frac == 14'd0);
        res_d.special = (exp_max == EXP_SPECIAL);
    end

    assign in_ready  = (count_q != 2'd2);
    assign out_valid = (count_q != 2'd0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // Occupancy and pointer next-state.
    always_comb begin
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            wr_ptr_d = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        if (push && !pop) begin
            count_d = count_q + 2'd1;
        end else if (pop && !push) begin
            count_d = count_q - 2'd1;
        end
    end

    // Control state registers.
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            count_q  <= 2'd0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
        end else begin
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Result storage, written at the accepting edge.
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
        end else if (push) begin
            mem_q[wr_ptr_q] <= res_d;
        end
    end

    assign head        = mem_q[rd_ptr_q];
    assign out_sign    = head.sign;
    assign out_frac    = head.frac;
    assign out_exp     = head.exp;
    assign out_sticky  = head.sticky;
    assign out_zero    = head.zero;
    assign out_special = head.special;

endmodule

// File: doc/add_frac_stage.md
# add_frac_stage

Second stage of the three-step FP16 add pipeline for the systolic array. Consumes the aligned operands produced by the alignment stage: the sign and 13-bit fraction of the shifted and unshifted operands, the max exponent and the rounding-loss bit. It performs the signed-magnitude add or subtract of the two fractions and registers the result with its metadata. The result sits in a 2-entry output buffer with valid/ready handshakes toward the normalize/round stage.

## Interface
- No parameters; all widths fixed for FP16 (5-bit exponent, 13-bit aligned fraction).
- clk  in  1  clock; all state updates on rising edge.
- nRST  in  1  asynchronous, active-low reset.
- in_valid  in  1  upstream operand set valid.
- in_ready  out  1  stage can accept this cycle.
- sign_shifted  in  1  sign of aligned (shifted) operand.
- frac_shifted  in  13  aligned fraction, format {lead, frac[9:0], 2'b00} >> diff.
- sign_not_shifted  in  1  sign of larger-exponent operand.
- frac_not_shifted  in  13  unshifted fraction.
- exp_max  in  5  larger exponent.
- rounding_loss  in  1  sticky: nonzero bits shifted out during alignment.
- out_valid  out  1  result at buffer head valid.
- out_ready  in  1  downstream accepts head this cycle.
- out_sign  out  1  result sign.
- out_frac  out  14  result magnitude; bit 13 = carry-out.
- out_exp  out  5  exp_max passthrough.
- out_sticky  out  1  rounding_loss passthrough.
- out_zero  out  1  out_frac == 0.
- out_special  out  1  exp_max == 5'h1F (Inf/NaN input; result fields don't-care).

## Operation
- Transfer in: in_valid && in_ready. Transfer out: out_valid && out_ready.
- Operands zero-extended to 14 bits: S = {1'b0, frac_shifted}, N = {1'b0, frac_not_shifted}.
- Equal signs: out_frac = N + S (14-bit, never overflows); out_sign = sign_not_shifted.
- Opposite signs, N >= S: out_frac = N - S; out_sign = sign_not_shifted.
- Opposite signs, N < S (possible only for equal exponents): out_frac = S - N; out_sign = sign_shifted.
- Exact cancellation (opposite signs, N == S): out_frac = 0, out_sign = 0, out_zero = 1.
- out_exp, out_sticky and out_special are computed from the same accepted operand set and stored alongside.
- The sticky bit is not folded into the magnitude. Downstream applies it.
- Buffer: 2-entry FIFO of computed results (sign, frac, exp, sticky, zero, special). Arithmetic is done combinationally on input and the result is written at the accepting edge.
- count in {0,1,2}; in_ready = (count != 2), decoded from registers only, with no combinational path from out_ready.
- out_valid = (count != 0); out_* driven from the head entry.
- Push and pop in the same cycle: count unchanged, order preserved. When count==2 there is no push, since in_ready=0.
- Write/read pointers are 1 bit each and wrap 1->0.

## Timing
- Latency 1: operands accepted at edge k appear on out_* with out_valid=1 after edge k when the buffer was empty.
- Throughput: 1 result/cycle sustained while out_ready=1.
- If out_ready stays low, 2 results are accepted, then in_ready drops after the 2nd accepting edge.
- in_ready returns to 1 the cycle after the first pop from full.
- The head entry is stable while out_valid && !out_ready.
- Reset, asynchronous on nRST low: count=0, pointers=0, out_valid=0, in_ready=1.
- Reset also clears out_sign, out_frac, out_exp, out_sticky, out_zero and out_special to 0 (storage cleared).
- Reset mid-operation discards buffered results. No output transfer occurs while nRST is low.

## Test plan
- Add 1.0+1.0: N=S=0x1000, signs 0, exp_max=15. Expect out_frac=0x2000, out_sign=0, out_exp=15, out_valid the cycle after acceptance.
- Subtract 1.0-0.5: N=0x1000 sign 0, S=0x0800 sign 1, exp_max=15, rounding_loss=0. Expect out_frac=0x0800, out_sign=0, out_sticky=0.
- Equal-exponent swap: N=0x1000 sign 0, S=0x1800 sign 1. Expect out_frac=0x0800, out_sign=1. Cancellation case N=S=0x1000, opposite signs: expect out_frac=0, out_sign=0, out_zero=1.
- Backpressure: out_ready=0, in_valid=1 for 3 cycles with distinct operands A, B, C. Expect A and B accepted and in_ready=0 on the 3rd cycle. Raise out_ready: expect outputs A, B, C in order, with no loss or duplication.
- Streaming: in_valid=out_ready=1 for 8 cycles, rounding_loss alternating. Expect 8 outputs back-to-back, count held at 1, and out_sticky matching each input.
- Special plus reset: exp_max=31 gives out_special=1. Assert nRST low with 2 entries buffered: expect out_valid=0 and in_ready=1 immediately, with all out_* equal to 0.
